// File: rtl/lcd_pkg.sv
// Shared opcodes, scheduler state encoding and image geometry for the LCD command path.
package lcd_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_WRITE    = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP       = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN     = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT     = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT    = 3'd4;
    localparam logic [CMD_W-1:0] CMD_AVG      = 3'd5;
    localparam logic [CMD_W-1:0] CMD_MIRROR_X = 3'd6;
    localparam logic [CMD_W-1:0] CMD_MIRROR_Y = 3'd7;

    localparam int IMG_W      = 8;
    localparam int IMG_H      = 8;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HALT      = 2'd3
    } sched_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small host command FIFO; pointers carry an extra wrap bit so full/empty come straight from them.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CMD_W-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CMD_W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok  = push_i & ~full_o;
    assign pop_ok   = pop_i & ~empty_o;
    assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Issues buffered host commands to the LCD controller one at a time and supervises the final WRITE.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] issued_cnt,
    output logic       seq_done,
    output logic       err_timeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    sched_state_e state_q, state_d;
    logic [2:0]   lcd_cmd_q, lcd_cmd_d;
    logic         valid_q, valid_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         seq_done_q, seq_done_d;
    logic         err_q, err_d;
    logic         wr_seen_q, wr_seen_d;
    logic [7:0]   wd_q, wd_d;

    logic         fifo_full, fifo_empty, fifo_pop, host_push;
    logic [2:0]   fifo_head;

    assign host_ready = ~fifo_full & ~wr_seen_q & (state_q != ST_HALT);
    assign host_push  = host_valid & host_ready;
    assign wr_seen_d  = wr_seen_q | (host_push & (host_cmd == CMD_WRITE));

    lcd_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_ni (reset),
        .push_i (host_push),
        .pop_i  (fifo_pop),
        .din_i  (host_cmd),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        lcd_cmd_d  = lcd_cmd_q;
        valid_d    = 1'b0;
        cnt_d      = cnt_q;
        seq_done_d = seq_done_q;
        err_d      = err_q;
        wd_d       = wd_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!lcd_busy && !fifo_empty) begin
                    lcd_cmd_d = fifo_head;
                    valid_d   = 1'b1;
                    fifo_pop  = 1'b1;
                    cnt_d     = sat_inc8(cnt_q);
                    wd_d      = 8'd0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                // Busy acknowledgement takes priority over a watchdog expiring in the same cycle.
                if (lcd_busy) begin
                    wd_d    = 8'd0;
                    state_d = (lcd_cmd_q == CMD_WRITE) ? ST_WAIT_DONE : ST_IDLE;
                end else if (wd_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (lcd_done) begin
                    seq_done_d = 1'b1;
                    state_d    = ST_HALT;
                end else if (wd_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lcd_cmd_q  <= 3'd0;
            valid_q    <= 1'b0;
            cnt_q      <= 8'd0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            wr_seen_q  <= 1'b0;
            wd_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            lcd_cmd_q  <= lcd_cmd_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            wr_seen_q  <= wr_seen_d;
            wd_q       <= wd_d;
        end
    end

    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign issued_cnt    = cnt_q;
    assign seq_done      = seq_done_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scoreboard bench for lcd_cmd_sched: pushes expected issues into a queue, a monitor pops on each pulse.
module tb_lcd_cmd_sched;

    localparam int TIMEOUT = 255;
    localparam int B_COMP  = 0;
    localparam int B_HIGH  = 1;
    localparam int B_LOW   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] host_cmd = 3'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       lcd_busy = 1'b0;
    logic       lcd_done = 1'b0;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] issued_cnt;
    logic       seq_done;
    logic       err_timeout;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         issue_cyc = 0;
    int         n_issues = 0;
    int         bmode = B_COMP;
    int         bcnt = 0;
    logic       busy_at_edge = 1'b0;
    logic       valid_prev = 1'b0;
    logic [2:0] mon_exp;
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    lcd_cmd_sched #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .lcd_busy     (lcd_busy),
        .lcd_done     (lcd_done),
        .lcd_cmd      (lcd_cmd),
        .lcd_cmd_valid(lcd_cmd_valid),
        .issued_cnt   (issued_cnt),
        .seq_done     (seq_done),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= lcd_busy;
    end

    // Monitor: every issue pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (reset && lcd_cmd_valid) begin
            n_issues++;
            issue_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_issue: got cmd %0d, expected no issue (cycle %0d)", lcd_cmd, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_cmd", 32'(lcd_cmd), 32'(mon_exp));
            end
            check("issue_while_busy", 32'(busy_at_edge), 32'd0);
            check("valid_pulse_width", 32'(valid_prev), 32'd0);
            $display("issue #%0d cmd=%0d issued_cnt=%0d cycle=%0d", n_issues, lcd_cmd, issued_cnt, cyc);
        end
        valid_prev = lcd_cmd_valid;
    end

    // Controller busy model: busy rises one cycle after the pulse and stays high for two cycles.
    always @(negedge clk) begin
        case (bmode)
            B_HIGH: begin lcd_busy = 1'b1; bcnt = 0; end
            B_LOW:  begin lcd_busy = 1'b0; bcnt = 0; end
            default: begin
                if (bcnt == 0) begin
                    lcd_busy = 1'b0;
                    if (reset && lcd_cmd_valid) bcnt = 1;
                end else if (bcnt == 1) begin
                    lcd_busy = 1'b1;
                    bcnt = 2;
                end else if (bcnt == 2) begin
                    bcnt = 3;
                end else begin
                    lcd_busy = 1'b0;
                    bcnt = 0;
                end
            end
        endcase
        if (!reset) bcnt = 0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        host_valid = 1'b0;
        lcd_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_cmd(input logic [2:0] c, input bit expect_issue);
        host_cmd = c;
        host_valid = 1'b1;
        for (int i = 0; i < 200 && !host_ready; i++) @(negedge clk);
        check("push_accept", 32'(host_ready), 32'd1);
        if (host_ready) begin
            if (expect_issue) exp_q.push_back(c);
            $display("push cmd=%0d cycle=%0d", c, cyc);
        end
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int n_before;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_host_ready", 32'(host_ready), 32'd1);
        check("rst_valid", 32'(lcd_cmd_valid), 32'd0);
        check("rst_cmd", 32'(lcd_cmd), 32'd0);
        check("rst_cnt", 32'(issued_cnt), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Issue sequence with compliant busy; a stray done while idle is ignored.
        bmode = B_COMP;
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        @(negedge clk);
        check("done_ignored_idle", 32'(seq_done), 32'd0);
        push_cmd(3'd4, 1'b1);
        push_cmd(3'd4, 1'b1);
        push_cmd(3'd5, 1'b1);
        wait_drained(100);
        repeat (6) @(negedge clk);
        check("t2_issued_cnt", 32'(issued_cnt), 32'd3);
        check("t2_cmd_held", 32'(lcd_cmd), 32'd5);

        // Reset in the middle of WAIT_DONE.
        do_reset();
        push_cmd(3'd0, 1'b1);
        wait_drained(50);
        repeat (8) @(negedge clk);
        check("t1_pre_seq_done", 32'(seq_done), 32'd0);
        check("t1_pre_cnt", 32'(issued_cnt), 32'd1);
        reset = 1'b0;
        #1;
        check("t1_rst_valid", 32'(lcd_cmd_valid), 32'd0);
        check("t1_rst_cmd", 32'(lcd_cmd), 32'd0);
        check("t1_rst_cnt", 32'(issued_cnt), 32'd0);
        check("t1_rst_seq_done", 32'(seq_done), 32'd0);
        check("t1_rst_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t1_host_ready", 32'(host_ready), 32'd1);
        n_before = n_issues;
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        repeat (4) @(negedge clk);
        check("t1_no_issue", 32'(n_issues), 32'(n_before));
        check("t1_done_ignored", 32'(seq_done), 32'd0);

        // FIFO fill with busy held high, then release.
        bmode = B_HIGH;
        do_reset();
        @(negedge clk);
        push_cmd(3'd1, 1'b1);
        push_cmd(3'd2, 1'b1);
        push_cmd(3'd3, 1'b1);
        push_cmd(3'd6, 1'b1);
        check("t3_full_ready", 32'(host_ready), 32'd0);
        host_cmd = 3'd7;
        host_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_full_hold", 32'(host_ready), 32'd0);
        end
        check("t3_no_issue_busy", 32'(issued_cnt), 32'd0);
        bmode = B_COMP;
        push_cmd(3'd7, 1'b1);
        wait_drained(200);
        repeat (6) @(negedge clk);
        check("t3_issued_cnt", 32'(issued_cnt), 32'd5);

        // WRITE terminates the sequence; later host commands are refused.
        do_reset();
        push_cmd(3'd1, 1'b1);
        push_cmd(3'd0, 1'b1);
        host_cmd = 3'd3;
        host_valid = 1'b1;
        check("t4_refuse_after_write", 32'(host_ready), 32'd0);
        @(negedge clk);
        check("t4_refuse_after_write2", 32'(host_ready), 32'd0);
        host_valid = 1'b0;
        wait_drained(100);
        for (int i = 0; i < 200 && cyc < issue_cyc + 66; i++) @(negedge clk);
        check("t4_pre_done", 32'(seq_done), 32'd0);
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        check("t4_seq_done", 32'(seq_done), 32'd1);
        check("t4_halt_ready", 32'(host_ready), 32'd0);
        check("t4_issued_cnt", 32'(issued_cnt), 32'd2);
        check("t4_no_err", 32'(err_timeout), 32'd0);

        // Busy never rises: watchdog expires TIMEOUT+1 cycles after ACK entry.
        bmode = B_LOW;
        do_reset();
        push_cmd(3'd2, 1'b1);
        wait_drained(50);
        t0 = issue_cyc;
        n_before = n_issues;
        for (int i = 0; i < 400 && !err_timeout; i++) @(negedge clk);
        check("t5_timeout_latency", 32'(cyc - t0), 32'(TIMEOUT + 1));
        repeat (5) @(negedge clk);
        check("t5_no_reissue", 32'(n_issues), 32'(n_before));
        check("t5_err_sticky", 32'(err_timeout), 32'd1);
        check("t5_halt_ready", 32'(host_ready), 32'd0);
        check("t5_no_seq_done", 32'(seq_done), 32'd0);

        // 256 non-WRITE issues: counter saturates at 255.
        bmode = B_COMP;
        do_reset();
        n_before = n_issues;
        for (int i = 0; i < 256; i++) push_cmd(3'(1 + (i % 7)), 1'b1);
        wait_drained(2000);
        repeat (6) @(negedge clk);
        check("t6_issue_total", 32'(n_issues - n_before), 32'd256);
        check("t6_cnt_saturated", 32'(issued_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
